// File: rtl/prbs_stream_checker.sv
// PRBS-31 stream checker: self-synchronises to a valid/ready word stream, reports lock and counts errors.
// Optional build macro PRBS_CHK_BIT_ERR_EN: err_cnt accumulates mismatching bits instead of mismatching words.
module prbs_stream_checker #(
   parameter int         P_DATA_W     = 32,
   parameter logic [4:0] P_LOCK_CNT   = 5'h08,
   parameter logic [4:0] P_UNLOCK_CNT = 5'h04,
   parameter int         P_CNT_W      = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [P_DATA_W-1:0] s_data,
   input  logic                clr_cnt,
   output logic                locked,
   output logic                err_pulse,
   output logic [P_CNT_W-1:0]  err_cnt,
   output logic [P_CNT_W-1:0]  word_cnt
);

   localparam logic [5:0] LOCK_N   = (P_LOCK_CNT == 5'd0)   ? 6'd1 : {1'b0, P_LOCK_CNT};
   localparam logic [5:0] UNLOCK_N = (P_UNLOCK_CNT == 5'd0) ? 6'd1 : {1'b0, P_UNLOCK_CNT};
   localparam int         POP_W    = $clog2(P_DATA_W + 1);
   localparam int         SUM_W    = ((P_CNT_W > POP_W) ? P_CNT_W : POP_W) + 1;
   localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({P_CNT_W{1'b1}});

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      LOCKING = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [30:0]          lfsr_q, lfsr_d;
   logic [4:0]           match_q, match_d;
   logic [4:0]           miss_q, miss_d;
   logic [P_DATA_W-1:0]  expected;
   logic                 accept;
   logic                 mismatch;
   logic                 check_locked;
   logic [SUM_W-1:0]     err_amt;
   logic [5:0]           match_next;
   logic [5:0]           miss_next;

   // lfsr[0] is the newest bit, lfsr[30] the oldest (b[n-31]); the first bit produced lands in the word MSB.
   function automatic logic [P_DATA_W-1:0] prbs_advance(input logic [30:0] seed);
      logic [30:0]         s;
      logic                nb;
      logic [P_DATA_W-1:0] w;
      s = seed;
      w = '0;
      for (int i = P_DATA_W - 1; i >= 0; i--) begin
         nb   = s[30] ^ s[27];
         w[i] = nb;
         s    = {s[29:0], nb};
      end
      return w;
   endfunction

`ifdef PRBS_CHK_BIT_ERR_EN
   function automatic logic [POP_W-1:0] popcount(input logic [P_DATA_W-1:0] v);
      logic [POP_W-1:0] c;
      c = '0;
      for (int i = 0; i < P_DATA_W; i++) begin
         c = c + POP_W'(v[i]);
      end
      return c;
   endfunction
`endif

   function automatic logic [P_CNT_W-1:0] sat_add(input logic [P_CNT_W-1:0] a,
                                                  input logic [SUM_W-1:0]   b);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(a) + b;
      return (sum > CNT_MAX) ? {P_CNT_W{1'b1}} : sum[P_CNT_W-1:0];
   endfunction

   assign s_ready      = ~rst;
   assign accept       = s_valid & s_ready;
   assign expected     = prbs_advance(lfsr_q);
   assign mismatch     = (s_data != expected);
   assign check_locked = accept & (state_q == LOCKED);
   assign locked       = (state_q == LOCKED);
   assign match_next   = {1'b0, match_q} + 6'd1;
   assign miss_next    = {1'b0, miss_q} + 6'd1;

`ifdef PRBS_CHK_BIT_ERR_EN
   assign err_amt = SUM_W'(popcount(s_data ^ expected));
`else
   assign err_amt = SUM_W'(1);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HUNT;
         lfsr_q  <= '0;
         match_q <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         match_q <= match_d;
         miss_q  <= miss_d;
      end
   end

   // Once locked the LFSR free-runs on its own prediction, so corrupted words never disturb the reference.
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      match_d = match_q;
      miss_d  = miss_q;
      case (state_q)
         HUNT: begin
            if (accept) begin
               lfsr_d  = s_data[30:0];
               match_d = '0;
               miss_d  = '0;
               state_d = LOCKING;
            end
         end
         LOCKING: begin
            if (accept) begin
               if (!mismatch) begin
                  lfsr_d  = expected[30:0];
                  match_d = match_next[4:0];
                  if (match_next >= LOCK_N) begin
                     state_d = LOCKED;
                     miss_d  = '0;
                  end
               end else begin
                  lfsr_d  = s_data[30:0];
                  match_d = '0;
               end
            end
         end
         LOCKED: begin
            if (accept) begin
               lfsr_d = expected[30:0];
               if (mismatch) begin
                  miss_d = miss_next[4:0];
                  if (miss_next >= UNLOCK_N) begin
                     state_d = HUNT;
                     miss_d  = '0;
                     match_d = '0;
                  end
               end else begin
                  miss_d = '0;
               end
            end
         end
         default: begin
            state_d = HUNT;
         end
      endcase
   end

   // A clear request takes priority over any increment landing in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_pulse <= 1'b0;
         err_cnt   <= '0;
         word_cnt  <= '0;
      end else begin
         err_pulse <= check_locked & mismatch;
         if (clr_cnt) begin
            err_cnt  <= '0;
            word_cnt <= '0;
         end else if (check_locked) begin
            word_cnt <= sat_add(word_cnt, SUM_W'(1));
            if (mismatch) begin
               err_cnt <= sat_add(err_cnt, err_amt);
            end
         end
      end
   end

endmodule
